// File: rtl/hsi_rx_msg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hsi_rx_msg_ctrl_pkg
// Shared HSI configuration package: link-wide constants, receive-controller
// state encoding, message error codes and the default message-size and
// inter-byte gap limits.
// ---------------------------------------------------------------------------
package hsi_rx_msg_ctrl_pkg;

  // Link constants
  localparam int unsigned HSI_BYTE_W          = 8;
  localparam int unsigned HSI_LEN_W           = 6;
  localparam int unsigned HSI_GAP_W           = 16;

  // Receive controller defaults
  localparam int unsigned HSI_DEF_MAX_LEN     = 16;
  localparam int unsigned HSI_DEF_GAP_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } hsi_rx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PARITY   = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_GAP      = 2'd3
  } hsi_err_e;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int unsigned hsi_addr_w(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/hsi_rx_msg_ctrl_if.sv
// ---------------------------------------------------------------------------
// hsi_rx_msg_ctrl_if
// Host-side message stream of the HSI receive controller.
//   out_data/out_valid/out_ready/out_last : byte stream with ready/valid
//   msg_len                               : length of the message in flight
//   msg_err/err_code                      : discard pulse and its cause
// master = controller, slave = host.
// ---------------------------------------------------------------------------
interface hsi_rx_msg_ctrl_if;
  import hsi_rx_msg_ctrl_pkg::*;

  logic [HSI_BYTE_W-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [HSI_LEN_W-1:0]  msg_len;
  logic                  msg_err;
  logic [1:0]            err_code;

  modport master (
    output out_data, out_valid, out_last, msg_len, msg_err, err_code,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_last, msg_len, msg_err, err_code,
    output out_ready
  );

endinterface

// File: rtl/hsi_msg_buf.sv
// ---------------------------------------------------------------------------
// hsi_msg_buf
// Message byte buffer: DEPTH x 8, one registered write port, one
// combinational read port. Contents are not reset; the controller tracks
// which entries are valid.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
// ---------------------------------------------------------------------------
module hsi_msg_buf
  import hsi_rx_msg_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = HSI_DEF_MAX_LEN,
  parameter int unsigned AW    = hsi_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [HSI_BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [HSI_BYTE_W-1:0] rdata_o
);

  logic [HSI_BYTE_W-1:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hsi_rx_msg_ctrl.sv
// ---------------------------------------------------------------------------
// hsi_rx_msg_ctrl
// Collects decoded bytes into a message buffer and, on end-of-message,
// drains them to the host over a ready/valid stream. Parity errors,
// buffer overflow and inter-byte gap timeouts discard the message, pulse
// msg_err with a cause code and hold the decoder in reset for two cycles.
//   clk, n_rst   : clock, synchronous active-low reset
//   clk_en       : bit-sample tick, advances the gap timer
//   rx_en        : host receive enable
//   dc_q ...     : decoder byte / parity-error / end-of-message pulses
//   dc_n_rst     : decoder reset (active-low)
//   host_if      : host-side message stream (master)
// ---------------------------------------------------------------------------
module hsi_rx_msg_ctrl
  import hsi_rx_msg_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN     = HSI_DEF_MAX_LEN,
  parameter int unsigned GAP_TIMEOUT = HSI_DEF_GAP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clk_en,
  input  logic                  rx_en,
  input  logic [HSI_BYTE_W-1:0] dc_q,
  input  logic                  dc_q_rdy,
  input  logic                  dc_err,
  input  logic                  dc_msg_end,
  output logic                  dc_n_rst,
  hsi_rx_msg_ctrl_if.master     host_if
);

  localparam int unsigned          AW        = hsi_addr_w(MAX_LEN);
  localparam logic [HSI_LEN_W-1:0] MAX_LEN_C = HSI_LEN_W'(MAX_LEN);
  localparam logic [HSI_GAP_W-1:0] GAP_LIM_C = HSI_GAP_W'(GAP_TIMEOUT);

  hsi_rx_state_e         state_q, state_d;
  logic [HSI_LEN_W-1:0]  count_q, count_d;
  logic [HSI_GAP_W-1:0]  gap_q, gap_d;
  logic                  flush_q, flush_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic                  dc_n_rst_q, dc_n_rst_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [HSI_BYTE_W-1:0] out_data_q, out_data_d;
  logic [HSI_LEN_W-1:0]  msg_len_q, msg_len_d;
  logic                  msg_err_q, msg_err_d;
  hsi_err_e              err_code_q, err_code_d;

  logic                  we_s;
  logic [AW-1:0]         raddr_s;
  logic [AW-1:0]         rd_nxt_s;
  logic [HSI_BYTE_W-1:0] rdata_s;
  logic [HSI_GAP_W-1:0]  gap_inc_s;

  assign rd_nxt_s  = rd_q + AW'(1'b1);
  assign gap_inc_s = gap_q + {{(HSI_GAP_W-1){1'b0}}, 1'b1};
  // Output registers load the byte they will present next: entry to DRAIN
  // needs byte 0, each accepted transfer needs the following byte.
  assign raddr_s   = (state_q == ST_DRAIN) ? rd_nxt_s : {AW{1'b0}};

  hsi_msg_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (dc_q),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Next-state and next-output logic for the receive/drain FSM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    gap_d       = gap_q;
    flush_d     = flush_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    msg_len_d   = msg_len_q;
    msg_err_d   = 1'b0;
    err_code_d  = ERR_NONE;
    we_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d     = {HSI_LEN_W{1'b0}};
        gap_d       = {HSI_GAP_W{1'b0}};
        rd_d        = {AW{1'b0}};
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (rx_en && dc_q_rdy) begin
          we_s    = 1'b1;
          count_d = {{(HSI_LEN_W-1){1'b0}}, 1'b1};
          state_d = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (!rx_en) begin
          // Host abort: silent discard
          count_d = {HSI_LEN_W{1'b0}};
          gap_d   = {HSI_GAP_W{1'b0}};
          state_d = ST_IDLE;
        end else if (dc_err) begin
          msg_err_d  = 1'b1;
          err_code_d = ERR_PARITY;
          flush_d    = 1'b0;
          state_d    = ST_FLUSH;
        end else if (dc_q_rdy && (count_q == MAX_LEN_C)) begin
          msg_err_d  = 1'b1;
          err_code_d = ERR_OVERFLOW;
          flush_d    = 1'b0;
          state_d    = ST_FLUSH;
        end else if (dc_msg_end && (count_q != {HSI_LEN_W{1'b0}})) begin
          msg_len_d   = count_q;
          rd_d        = {AW{1'b0}};
          out_valid_d = 1'b1;
          out_data_d  = rdata_s;
          out_last_d  = (count_q == {{(HSI_LEN_W-1){1'b0}}, 1'b1});
          state_d     = ST_DRAIN;
        end else if (dc_q_rdy) begin
          we_s    = 1'b1;
          count_d = count_q + {{(HSI_LEN_W-1){1'b0}}, 1'b1};
          gap_d   = {HSI_GAP_W{1'b0}};
        end else if (clk_en) begin
          gap_d = gap_inc_s;
          if (gap_inc_s >= GAP_LIM_C) begin
            msg_err_d  = 1'b1;
            err_code_d = ERR_GAP;
            flush_d    = 1'b0;
            state_d    = ST_FLUSH;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          gap_d = gap_q;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && host_if.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            rd_d       = rd_nxt_s;
            out_data_d = rdata_s;
            out_last_d = ({{(HSI_LEN_W-AW){1'b0}}, rd_nxt_s} ==
                          (msg_len_q - {{(HSI_LEN_W-1){1'b0}}, 1'b1}));
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_FLUSH: begin
        count_d = {HSI_LEN_W{1'b0}};
        gap_d   = {HSI_GAP_W{1'b0}};
        // Two FLUSH cycles hold the decoder in reset
        if (flush_q) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Decoder runs only while collecting, or idle with the host enabled
    dc_n_rst_d = (state_d == ST_RECV) || ((state_d == ST_IDLE) && rx_en);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      count_q     <= {HSI_LEN_W{1'b0}};
      gap_q       <= {HSI_GAP_W{1'b0}};
      flush_q     <= 1'b0;
      rd_q        <= {AW{1'b0}};
      dc_n_rst_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {HSI_BYTE_W{1'b0}};
      msg_len_q   <= {HSI_LEN_W{1'b0}};
      msg_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      flush_q     <= flush_d;
      rd_q        <= rd_d;
      dc_n_rst_q  <= dc_n_rst_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      msg_len_q   <= msg_len_d;
      msg_err_q   <= msg_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign dc_n_rst         = dc_n_rst_q;
  assign host_if.out_data  = out_data_q;
  assign host_if.out_valid = out_valid_q;
  assign host_if.out_last  = out_last_q;
  assign host_if.msg_len   = msg_len_q;
  assign host_if.msg_err   = msg_err_q;
  assign host_if.err_code  = err_code_q;

endmodule

// File: tb/tb_hsi_rx_msg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hsi_rx_msg_ctrl
// Scoreboard bench for hsi_rx_msg_ctrl: expected host beats and error codes
// are queued as stimulus is driven and popped by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_hsi_rx_msg_ctrl;
  import hsi_rx_msg_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst, clk_en, rx_en, dc_q_rdy, dc_err, dc_msg_end, dc_n_rst;
  logic [7:0] dc_q;

  always #5 clk = ~clk;

  hsi_rx_msg_ctrl_if host_if();

  hsi_rx_msg_ctrl #(
    .MAX_LEN     (16),
    .GAP_TIMEOUT (255)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clk_en     (clk_en),
    .rx_en      (rx_en),
    .dc_q       (dc_q),
    .dc_q_rdy   (dc_q_rdy),
    .dc_err     (dc_err),
    .dc_msg_end (dc_msg_end),
    .dc_n_rst   (dc_n_rst),
    .host_if    (host_if)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [5:0] len;
  } exp_beat_t;

  exp_beat_t  exp_q[$];
  logic [1:0] err_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dc_q     = b;
    dc_q_rdy = 1'b1;
    tick();
    dc_q_rdy = 1'b0;
  endtask

  task automatic pulse_end();
    dc_msg_end = 1'b1;
    tick();
    dc_msg_end = 1'b0;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic [5:0] len);
    exp_beat_t b;
    b.data = d;
    b.last = l;
    b.len  = len;
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (((exp_q.size() + err_q.size()) != 0) && (n < max_cyc)) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, exp_q.size() + err_q.size(), 32'd0);
    repeat (3) tick();
  endtask

  // Monitor: scoreboard pops, stall stability, spurious beats/errors
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    exp_beat_t  b;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1) begin
        if (prev_stall) begin
          check_eq("stall_valid", host_if.out_valid, 32'd1);
          check_eq("stall_data", host_if.out_data, prev_data);
          check_eq("stall_last", host_if.out_last, prev_last);
        end
        if (host_if.out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_valid", host_if.out_valid, 32'd0);
          end else if (host_if.out_ready === 1'b1) begin
            b = exp_q.pop_front();
            check_eq("out_data", host_if.out_data, b.data);
            check_eq("out_last", host_if.out_last, b.last);
            check_eq("msg_len", host_if.msg_len, b.len);
          end
        end
        if (host_if.msg_err === 1'b1) begin
          if (err_q.size() == 0) begin
            check_eq("spurious_err", host_if.msg_err, 32'd0);
          end else begin
            check_eq("err_code", host_if.err_code, err_q.pop_front());
          end
        end
        prev_stall = host_if.out_valid && !host_if.out_ready;
        prev_data  = host_if.out_data;
        prev_last  = host_if.out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int lows;
    n_rst = 1'b0; clk_en = 1'b0; rx_en = 1'b0;
    dc_q = 8'h00; dc_q_rdy = 1'b0; dc_err = 1'b0; dc_msg_end = 1'b0;
    host_if.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_dc_n_rst", dc_n_rst, 32'd0);
    check_eq("rst_out_valid", host_if.out_valid, 32'd0);
    check_eq("rst_out_last", host_if.out_last, 32'd0);
    check_eq("rst_out_data", host_if.out_data, 32'd0);
    check_eq("rst_msg_len", host_if.msg_len, 32'd0);
    check_eq("rst_msg_err", host_if.msg_err, 32'd0);
    check_eq("rst_err_code", host_if.err_code, 32'd0);

    n_rst = 1'b1; rx_en = 1'b1;
    tick();
    check_eq("idle_dc_n_rst", dc_n_rst, 32'd1);

    // Three bytes, back-to-back drain
    host_if.out_ready = 1'b1;
    expect_beat(8'hA5, 1'b0, 6'd3);
    expect_beat(8'h3C, 1'b0, 6'd3);
    expect_beat(8'hFF, 1'b1, 6'd3);
    send_byte(8'hA5); tick();
    send_byte(8'h3C); tick();
    send_byte(8'hFF); tick();
    pulse_end();
    check_eq("latency_valid", host_if.out_valid, 32'd1);
    check_eq("drain_dc_n_rst", dc_n_rst, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("b2b_valid", host_if.out_valid, 32'd1);
    end
    @(negedge clk);
    check_eq("drain_end_valid", host_if.out_valid, 32'd0);
    wait_done("msg3", 20);

    // Two bytes with toggling ready
    host_if.out_ready = 1'b0;
    expect_beat(8'h11, 1'b0, 6'd2);
    expect_beat(8'h22, 1'b1, 6'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_end();
    for (int i = 0; i < 10; i++) begin
      host_if.out_ready = (i % 2 == 1);
      tick();
    end
    host_if.out_ready = 1'b1;
    wait_done("stall", 20);
    check_eq("stall_idle_valid", host_if.out_valid, 32'd0);
    check_eq("stall_idle_dc_n_rst", dc_n_rst, 32'd1);

    // Overflow on the 17th byte
    err_q.push_back(2'd2);
    for (int i = 0; i < 17; i++) send_byte(8'(i + 1));
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dc_n_rst === 1'b0) lows++;
    end
    check_eq("flush_low_cycles", lows, 32'd2);
    tick();
    wait_done("overflow", 20);

    // Parity error, then a good one-byte message
    err_q.push_back(2'd1);
    send_byte(8'h77); tick();
    dc_err = 1'b1; tick(); dc_err = 1'b0;
    wait_done("parity", 20);
    expect_beat(8'h5A, 1'b1, 6'd1);
    send_byte(8'h5A); tick();
    pulse_end();
    wait_done("after_parity", 20);

    // Gap timeout on the 255th tick
    err_q.push_back(2'd3);
    send_byte(8'h42);
    clk_en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 254) check_eq("gap_before_limit", host_if.msg_err, 32'd0);
    end
    check_eq("gap_at_limit", host_if.msg_err, 32'd1);
    clk_en = 1'b0;
    wait_done("gap", 20);

    // dc_err and dc_msg_end together: parity wins, no drain
    err_q.push_back(2'd1);
    send_byte(8'h01);
    dc_err = 1'b1; dc_msg_end = 1'b1;
    tick();
    dc_err = 1'b0; dc_msg_end = 1'b0;
    wait_done("err_vs_end", 20);

    // rx_en abort: silent discard
    send_byte(8'h33);
    rx_en = 1'b0;
    tick();
    check_eq("abort_dc_n_rst", dc_n_rst, 32'd0);
    check_eq("abort_no_err", host_if.msg_err, 32'd0);
    rx_en = 1'b1;
    tick();
    pulse_end();
    repeat (3) tick();
    check_eq("abort_idle_dc_n_rst", dc_n_rst, 32'd1);

    // Reset in the middle of a stalled drain
    host_if.out_ready = 1'b0;
    expect_beat(8'hC1, 1'b0, 6'd3);
    expect_beat(8'hC2, 1'b0, 6'd3);
    expect_beat(8'hC3, 1'b1, 6'd3);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    pulse_end();
    tick();
    check_eq("pre_rst_valid", host_if.out_valid, 32'd1);
    n_rst = 1'b0;
    tick();
    check_eq("mid_rst_valid", host_if.out_valid, 32'd0);
    check_eq("mid_rst_dc_n_rst", dc_n_rst, 32'd0);
    check_eq("mid_rst_msg_len", host_if.msg_len, 32'd0);
    check_eq("mid_rst_msg_err", host_if.msg_err, 32'd0);
    exp_q.delete();
    n_rst = 1'b1;
    host_if.out_ready = 1'b1;
    tick();
    expect_beat(8'hD4, 1'b1, 6'd1);
    send_byte(8'hD4);
    pulse_end();
    wait_done("after_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
